// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes and FSM states.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [3:0] ALU_OP_MAX = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_t;

  function automatic logic op_is_illegal(input logic [3:0] ctrl);
    return ctrl > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone eligible requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = eligible;
    if (&eligible) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, one operation
// at a time, with a 1-deep response buffer per requester.
//
// state    | meaning
// ST_IDLE  | accepting; grant one eligible requester and latch its operands
// ST_EXEC  | operands on the ALU; result captured into the granted buffer
// ST_WRITE | result visible to requester; no acceptance this cycle
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_ctrl0,
  input  logic [3:0]        req_ctrl1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result0,
  output logic [DATA_W-1:0] rsp_result1,
  output logic [1:0]        rsp_zero,
  output logic [1:0]        rsp_err,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              last_gnt;
  logic [1:0]        eligible;
  logic [1:0]        gnt;
  logic              accept;

  logic [3:0]        op_ctrl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_id;

  logic [DATA_W-1:0] wr_result;
  logic              wr_zero;
  logic              wr_err;

  // A requester with an unconsumed result is not eligible, so only it stalls.
  assign eligible = req_valid & ~rsp_valid;

  rr_arb2 u_rr_arb2 (
    .eligible (eligible),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = 2'b00;
    case (state)
      ST_IDLE: begin
        if (rst_n) begin
          req_ready = gnt;
        end
        if (gnt != 2'b00) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Illegal op codes never trust the ALU return.
  always_comb begin
    wr_err    = op_is_illegal(op_ctrl);
    wr_result = wr_err ? '0 : alu_result;
    wr_zero   = !wr_err && (op_ctrl == ALU_SUB) && alu_zero;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt    <= 1'b1;
      op_ctrl     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= 1'b0;
      rsp_valid   <= 2'b00;
      rsp_result0 <= '0;
      rsp_result1 <= '0;
      rsp_zero    <= 2'b00;
      rsp_err     <= 2'b00;
    end else begin
      rsp_valid <= rsp_valid & ~rsp_ready;
      if (accept) begin
        last_gnt <= gnt[1];
        op_id    <= gnt[1];
        op_ctrl  <= gnt[1] ? req_ctrl1 : req_ctrl0;
        op_a     <= gnt[1] ? req_a1 : req_a0;
        op_b     <= gnt[1] ? req_b1 : req_b0;
      end
      if (state == ST_EXEC) begin
        rsp_valid[op_id] <= 1'b1;
        rsp_zero[op_id]  <= wr_zero;
        rsp_err[op_id]   <= wr_err;
        if (op_id) begin
          rsp_result1 <= wr_result;
        end else begin
          rsp_result0 <= wr_result;
        end
      end
    end
  end

  assign alu_ctrl = op_ctrl;
  assign alu_a    = op_a;
  assign alu_b    = op_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level
// model; the shared ALU is modelled behaviourally inside the bench.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [3:0]  req_ctrl0, req_ctrl1, alu_ctrl;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [31:0] rsp_result0, rsp_result1, alu_a, alu_b, alu_result;
  logic        alu_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ctrl0   (req_ctrl0),
    .req_ctrl1   (req_ctrl1),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result0 (rsp_result0),
    .rsp_result1 (rsp_result1),
    .rsp_zero    (rsp_zero),
    .rsp_err     (rsp_err),
    .alu_ctrl    (alu_ctrl),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Illegal ops get garbage with zero asserted, so any reliance on the ALU shows.
  always_comb begin
    alu_result = ref_alu(alu_ctrl, alu_a, alu_b);
    alu_zero   = (alu_ctrl > ALU_OP_MAX) ? 1'b1 : (alu_result == 32'd0);
  end

  int          n_vec = 0;
  int          n_err = 0;

  int          m_cnt;
  bit          m_last;
  logic [3:0]  m_ctrl;
  logic [31:0] m_a, m_b;
  bit          m_bv[2];
  logic [31:0] m_br[2];
  bit          m_bz[2], m_be[2];
  bit          m_pid;
  logic [31:0] m_pres;
  bit          m_pz, m_pe;

  logic [1:0]  s_ready, s_valid, s_zero, s_err;
  logic [31:0] s_res0, s_res1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_last = 1'b1;
    m_ctrl = 4'd0;
    m_a    = 32'd0;
    m_b    = 32'd0;
    for (int i = 0; i < 2; i++) begin
      m_bv[i] = 1'b0;
      m_br[i] = 32'd0;
      m_bz[i] = 1'b0;
      m_be[i] = 1'b0;
    end
  endtask

  function automatic logic [1:0] exp_gnt();
    bit e0, e1;
    if (!rst_n || m_cnt != 0) return 2'b00;
    e0 = req_valid[0] && !m_bv[0];
    e1 = req_valid[1] && !m_bv[1];
    if (e0 && e1) return m_last ? 2'b01 : 2'b10;
    return {e1, e0};
  endfunction

  task automatic model_edge(input logic [1:0] g);
    logic [31:0] r;
    bit          id;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) if (m_bv[i] && rsp_ready[i]) m_bv[i] = 1'b0;
    if (m_cnt == 2) begin
      m_bv[m_pid] = 1'b1;
      m_br[m_pid] = m_pres;
      m_bz[m_pid] = m_pz;
      m_be[m_pid] = m_pe;
    end
    if (m_cnt > 0) begin
      m_cnt--;
    end else if (g != 2'b00) begin
      id     = g[1];
      m_last = id;
      m_pid  = id;
      m_cnt  = 2;
      m_ctrl = id ? req_ctrl1 : req_ctrl0;
      m_a    = id ? req_a1 : req_a0;
      m_b    = id ? req_b1 : req_b0;
      m_pe   = (m_ctrl > 4'd10);
      r      = ref_alu(m_ctrl, m_a, m_b);
      m_pres = m_pe ? 32'd0 : r;
      m_pz   = (m_ctrl == ALU_SUB) && (r == 32'd0);
    end
  endtask

  // One clock: sample mid-cycle, compare against the model, then advance both.
  task automatic cycle();
    logic [1:0] g;
    #2;
    s_ready = req_ready;
    s_valid = rsp_valid;
    s_zero  = rsp_zero;
    s_err   = rsp_err;
    s_res0  = rsp_result0;
    s_res1  = rsp_result1;
    g = exp_gnt();
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("rsp_valid", 32'(rsp_valid), {30'd0, m_bv[1], m_bv[0]});
    for (int i = 0; i < 2; i++) begin
      if (m_bv[i]) begin
        chk($sformatf("rsp_result%0d", i), (i == 1) ? rsp_result1 : rsp_result0, m_br[i]);
        chk($sformatf("rsp_zero%0d", i), 32'(rsp_zero[i]), 32'(m_bz[i]));
        chk($sformatf("rsp_err%0d", i), 32'(rsp_err[i]), 32'(m_be[i]));
      end
    end
    chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    model_edge(g);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    req_valid = 2'b00;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic op0(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    req_ctrl0 = c;
    req_a0    = a;
    req_b0    = b;
    cycle();
    chk({tag, "_ready"}, 32'(s_ready), 32'd1);
    req_valid = 2'b00;
    cycle();
    chk({tag, "_exec_valid"}, 32'(s_valid[0]), 32'd0);
    cycle();
    chk({tag, "_write_valid"}, 32'(s_valid[0]), 32'd1);
    chk({tag, "_result"}, s_res0, exp);
    cycle();
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      1:       return $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_ctrl();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(11, 15));
    return 4'($urandom_range(0, 10));
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_ctrl0 = 4'd0;
    req_ctrl1 = 4'd0;
    req_a0    = 32'd0;
    req_b0    = 32'd0;
    req_a1    = 32'd0;
    req_b1    = 32'd0;
    @(posedge clk);
    #1;
    model_reset();
    do_reset();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result0", rsp_result0, 32'd0);
    chk("reset_result1", rsp_result1, 32'd0);
    chk("reset_zero", 32'(rsp_zero), 32'd0);
    chk("reset_err", 32'(rsp_err), 32'd0);

    // Lone add with immediate consume.
    op0("add", ALU_ADD, 32'd5, 32'd7, 32'd12);
    chk("add_zero", 32'(s_zero[0]), 32'd0);

    // Tie from reset goes to 0, then alternation.
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    req_ctrl0 = ALU_SUB; req_a0 = 32'd3;     req_b0 = 32'd3;
    req_ctrl1 = ALU_OR;  req_a1 = 32'h0F0;   req_b1 = 32'h00F;
    cycle();
    chk("rr_first", 32'(s_ready), 32'd1);
    cycle();
    cycle();
    chk("sub_valid", 32'(s_valid), 32'd1);
    chk("sub_result", s_res0, 32'd0);
    chk("sub_zero", 32'(s_zero[0]), 32'd1);
    cycle();
    chk("rr_second", 32'(s_ready), 32'd2);
    cycle();
    cycle();
    chk("or_valid", 32'(s_valid), 32'd2);
    chk("or_result", s_res1, 32'h0FF);
    cycle();
    chk("rr_alternate", 32'(s_ready), 32'd1);
    drain(3);

    // Full buffer stalls only its own requester.
    do_reset();
    rsp_ready = 2'b10;
    req_valid = 2'b01;
    req_ctrl0 = ALU_ADD; req_a0 = 32'd1; req_b0 = 32'd2;
    req_ctrl1 = ALU_XOR; req_a1 = 32'hF0F0; req_b1 = 32'h0FF0;
    cycle();
    chk("stall_first", 32'(s_ready), 32'd1);
    cycle();
    cycle();
    req_valid = 2'b11;
    cycle();
    chk("stall_other_served", 32'(s_ready), 32'd2);
    cycle();
    cycle();
    chk("stall_xor_result", s_res1, 32'hFF00);
    req_valid = 2'b01;
    cycle();
    chk("stall_blocked", 32'(s_ready), 32'd0);
    rsp_ready = 2'b11;
    cycle();
    chk("stall_release_valid", 32'(s_valid), 32'd1);
    chk("stall_release_result", s_res0, 32'd3);
    cycle();
    chk("stall_second_accept", 32'(s_ready), 32'd1);
    drain(3);

    // Illegal op code on requester 1.
    rsp_ready = 2'b11;
    req_valid = 2'b10;
    req_ctrl1 = 4'd13; req_a1 = 32'h1234_5678; req_b1 = 32'h1234_5678;
    cycle();
    chk("illegal_ready", 32'(s_ready), 32'd2);
    req_valid = 2'b00;
    cycle();
    cycle();
    chk("illegal_valid", 32'(s_valid), 32'd2);
    chk("illegal_result", s_res1, 32'd0);
    chk("illegal_err", 32'(s_err[1]), 32'd1);
    chk("illegal_zero", 32'(s_zero[1]), 32'd0);
    cycle();

    // Reset during EXEC drops the operation.
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    req_ctrl0 = ALU_ADD; req_a0 = 32'd9; req_b0 = 32'd9;
    cycle();
    req_valid = 2'b00;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("midreset_valid_a", 32'(s_valid), 32'd0);
    cycle();
    chk("midreset_valid_b", 32'(s_valid), 32'd0);
    req_valid = 2'b11;
    cycle();
    chk("midreset_tie", 32'(s_ready), 32'd1);
    drain(3);

    op0("sra", ALU_SRA, 32'hF000_0000, 32'd4, 32'hFF00_0000);
    op0("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    op0("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);

    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      req_ctrl0 = rand_ctrl();
      req_ctrl1 = rand_ctrl();
      req_a0    = rand_opnd();
      req_b0    = rand_opnd();
      req_a1    = rand_opnd();
      req_b1    = rand_opnd();
      cycle();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req_valid[1:0]  input  2  requester i presents an operation.
REQ-005 req_ready[1:0]  output  2  requester i operation accepted this cycle when valid&ready.
REQ-006 req_ctrl0, req_ctrl1  input  4 each  ALU op code (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sra).
REQ-007 req_a0, req_b0, req_a1, req_b1  input  DATA_W each  operands.
REQ-008 rsp_valid[1:0]  output  2  result available for requester i.
REQ-009 rsp_ready[1:0]  input  2  requester i consumes result when valid&ready.
REQ-010 rsp_result0, rsp_result1  output  DATA_W each  result; rsp_zero[1:0], rsp_err[1:0]  output  2 each  zero flag, illegal-op flag.
REQ-011 alu_ctrl  output  4; alu_a, alu_b  output  DATA_W  operands driven to the shared ALU.
REQ-012 alu_result  input  DATA_W; alu_zero  input  1  combinational ALU return.

Function
REQ-013 FSM states IDLE, EXEC, WRITE; IDLE->EXEC on acceptance, EXEC->WRITE unconditionally, WRITE->IDLE unconditionally.
REQ-014 Acceptance only in IDLE; requester i eligible iff req_valid[i] and its response buffer empty.
REQ-015 req_ready[i] asserted only for the granted requester, combinationally in IDLE; never both bits high.
REQ-016 Both eligible: grant the requester not granted last (round-robin pointer last_gnt, updated on each acceptance).
REQ-017 On acceptance ctrl/a/b and grant ID latched into operand register; alu_ctrl/alu_a/alu_b driven from that register only.
REQ-018 In EXEC, alu_result/alu_zero sampled at end of cycle into the granted requester's 1-deep response buffer.
REQ-019 Latency: accepted at edge N -> rsp_valid high after edge N+2 (visible in WRITE cycle); next acceptance earliest edge N+3.
REQ-020 Illegal ctrl (11..15): no ALU reliance; result 0, zero 0, err 1.
REQ-021 rsp_zero = alu_zero for op 1 only; 0 otherwise.
REQ-022 Response buffer holds result until rsp_valid&rsp_ready; buffer freed same edge; requester may be re-granted in the following IDLE cycle.
REQ-023 Response buffer full blocks only its own requester; other requester continues to be served.
REQ-024 rsp_ready without rsp_valid: no effect.
REQ-025 When idle, alu_ctrl/alu_a/alu_b hold last latched values (no toggling).

Reset
REQ-026 rst_n=0 at an edge: state IDLE, last_gnt=1 (requester 0 wins first tie), operand register 0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
REQ-027 req_ready=0 while rst_n=0.
REQ-028 Reset mid-operation drops in-flight operation and unconsumed results; no response issued for them.

Structure
REQ-029 Shared package holds op-code constants (ALU_ADD..ALU_SRA, width 4), ALU_OP_MAX=10, FSM state enum.
REQ-030 Sub-module rr_arb2 (2-way round-robin grant, inputs eligible[1:0], last_gnt; output gnt[1:0]) is the single natural sub-block.

Verification
REQ-031 Req0 add 5+7 alone, rsp_ready0=1 -> req_ready0 at edge N, rsp_valid0 at N+2, result 12, zero 0.
REQ-032 Both valid from reset, sub 3-3 on 0, or on 1 -> 0 granted first (result 0, zero 1), then 1; then both again -> 0 granted again only after 1 served (alternation).
REQ-033 rsp_ready0=0, req0 issues twice -> second stalled (req_ready0=0), req1 served meanwhile; raising rsp_ready0 releases first result, then second accepted.
REQ-034 Req1 ctrl=13 -> result 0, err1=1, zero1=0, same latency.
REQ-035 rst_n low during EXEC -> rsp_valid stays 0, state IDLE, next tie grants requester 0.
REQ-036 Req0 sra 0xF0000000 by 4 -> 0xFF000000; sltu 0xFFFFFFFF<1 -> 0; slt -1<1 -> 1.
